// File: rtl/hazard_pkg.sv
// Shared defaults, select-slice helper and countdown next-state priority for the hazard scoreboard.
package hazard_pkg;

  localparam int DEF_REG_AW  = 3;
  localparam int DEF_NUM_RD  = 2;
  localparam int DEF_MAX_LAT = 3;
  localparam int DEF_LAT_W   = 2;
  localparam int DEF_PERF_W  = 16;

  // Widest packed select bus the slice helper can take.
  localparam int SEL_MAX_W = 64;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_CLEAR,
    CNT_LOAD,
    CNT_DEC
  } cnt_op_e;

  function automatic logic [SEL_MAX_W-1:0] sel_slice(
    input logic [SEL_MAX_W-1:0] vec,
    input int                   idx,
    input int                   w
  );
    logic [SEL_MAX_W-1:0] mask;
    mask = (SEL_MAX_W'(1) << w) - SEL_MAX_W'(1);
    return (vec >> (idx * w)) & mask;
  endfunction

  // Flush beats a new load, and a load beats the running decrement.
  function automatic cnt_op_e cnt_next_op(
    input logic flush,
    input logic load,
    input logic busy
  );
    cnt_op_e op;
    if (flush)     op = CNT_CLEAR;
    else if (load) op = CNT_LOAD;
    else if (busy) op = CNT_DEC;
    else           op = CNT_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/hazard_reg_ctr.sv
// Pending-writeback countdown for one architectural register.
module hazard_reg_ctr
  import hazard_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_next;

  assign busy = (cnt != '0);

  always_comb begin
    cnt_next = cnt;
    case (cnt_next_op(flush, load, busy))
      CNT_CLEAR: cnt_next = '0;
      CNT_LOAD:  cnt_next = load_val;
      CNT_DEC:   cnt_next = cnt - LAT_W'(1);
      default:   cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW hazard scoreboard driving stall and the PC / IF-ID enables.
// Optional writeback bypass is enabled by defining HAZARD_FWD_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int MAX_LAT = DEF_MAX_LAT,
  parameter int LAT_W   = DEF_LAT_W,
  parameter int PERF_W  = DEF_PERF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [NUM_RD-1:0]        issue_rd_en,
  input  logic [NUM_RD*REG_AW-1:0] issue_rs,
  input  logic                     issue_we,
  input  logic [REG_AW-1:0]        issue_wsel,
  input  logic [LAT_W-1:0]         issue_lat,
  input  logic                     flush,
  output logic                     stall,
  output logic                     enPC,
  output logic                     enIFID,
  output logic [(2**REG_AW)-1:0]   busy_vec,
  output logic [PERF_W-1:0]        stall_cnt,
  output logic [NUM_RD-1:0]        fwd_hit
);

  localparam int NREG = 2**REG_AW;

  logic [LAT_W-1:0]  cnt [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   load;
  logic [REG_AW-1:0] rs_sel [NUM_RD];
  logic [NUM_RD-1:0] rd_block;
  logic              raw;
  logic              waw;
  logic              accept;
  logic              wr_ok;

  // A source is blocked while its register is busy; with bypass, the landing cycle is served.
  always_comb begin
    rd_block = '0;
`ifdef HAZARD_FWD_EN
    fwd_hit  = '0;
`endif
    for (int k = 0; k < NUM_RD; k++) begin
      rs_sel[k] = REG_AW'(sel_slice(SEL_MAX_W'(issue_rs), k, REG_AW));
`ifdef HAZARD_FWD_EN
      rd_block[k] = issue_rd_en[k] & busy[rs_sel[k]] & (cnt[rs_sel[k]] != LAT_W'(1));
      fwd_hit[k]  = issue_valid & issue_rd_en[k] & (cnt[rs_sel[k]] == LAT_W'(1));
`else
      rd_block[k] = issue_rd_en[k] & busy[rs_sel[k]];
`endif
    end
  end

`ifndef HAZARD_FWD_EN
  assign fwd_hit = '0;
`endif

  // An older write landing after a younger one to the same register would corrupt it.
  assign raw    = |rd_block;
  assign waw    = issue_we & (cnt[issue_wsel] > issue_lat);
  assign stall  = issue_valid & ~flush & (raw | waw);
  assign enPC   = ~stall;
  assign enIFID = ~stall;
  assign accept = issue_valid & ~stall & ~flush;

  // A zero latency is illegal; hardware drops it rather than loading an idle counter.
  assign wr_ok  = accept & issue_we & (issue_lat != '0);

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    assign load[r] = wr_ok & (issue_wsel == REG_AW'(r));

    hazard_reg_ctr #(
      .LAT_W    (LAT_W)
    ) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (load[r]),
      .load_val (issue_lat),
      .cnt      (cnt[r]),
      .busy     (busy[r])
    );
  end

  assign busy_vec = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + PERF_W'(1);
  end

  a_lat_legal: assert property (@(posedge clk) disable iff (rst)
    (accept & issue_we) |-> (issue_lat != '0 && int'(issue_lat) <= MAX_LAT));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, reset and saturation
// sequences, and randomized issue traffic against a landing-time reference model.
module tb_hazard_scoreboard;

  localparam int P_W    = 8;
  localparam int SC_MAX = (1 << P_W) - 1;

  logic           clk;
  logic           rst;
  logic           issue_valid;
  logic [1:0]     issue_rd_en;
  logic [5:0]     issue_rs;
  logic           issue_we;
  logic [2:0]     issue_wsel;
  logic [1:0]     issue_lat;
  logic           flush;
  logic           stall;
  logic           enPC;
  logic           enIFID;
  logic [7:0]     busy_vec;
  logic [P_W-1:0] stall_cnt;
  logic [1:0]     fwd_hit;
  logic [20:0]    obs;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard #(
    .REG_AW (3), .NUM_RD (2), .MAX_LAT (3), .LAT_W (2), .PERF_W (P_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd_en (issue_rd_en),
    .issue_rs    (issue_rs),
    .issue_we    (issue_we),
    .issue_wsel  (issue_wsel),
    .issue_lat   (issue_lat),
    .flush       (flush),
    .stall       (stall),
    .enPC        (enPC),
    .enIFID      (enIFID),
    .busy_vec    (busy_vec),
    .stall_cnt   (stall_cnt),
    .fwd_hit     (fwd_hit)
  );

  assign obs = {stall, enPC, enIFID, busy_vec, fwd_hit, stall_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each register remembers the cycle at which its pending write has landed.
  longint land [8];
  longint now;
  int     sc;

  function automatic int mcnt(input int r);
    return (land[r] > now) ? int'(land[r] - now) : 0;
  endfunction

  function automatic logic m_blocked(input int r);
`ifdef HAZARD_FWD_EN
    return (mcnt(r) > 1);
`else
    return (mcnt(r) != 0);
`endif
  endfunction

  function automatic logic m_stall();
    logic raw;
    logic waw;
    raw = 1'b0;
    for (int k = 0; k < 2; k++)
      if (issue_rd_en[k] && m_blocked(int'(issue_rs[k*3 +: 3]))) raw = 1'b1;
    waw = issue_we && (mcnt(int'(issue_wsel)) > int'(issue_lat));
    return issue_valid && !flush && (raw || waw);
  endfunction

  function automatic logic [20:0] m_expect();
    logic       st;
    logic [7:0] bv;
    logic [1:0] fh;
    st = m_stall();
    fh = 2'b00;
    for (int r = 0; r < 8; r++) bv[r] = (mcnt(r) != 0);
`ifdef HAZARD_FWD_EN
    for (int k = 0; k < 2; k++)
      fh[k] = issue_valid && issue_rd_en[k] && (mcnt(int'(issue_rs[k*3 +: 3])) == 1);
`endif
    return {st, ~st, ~st, bv, fh, P_W'(sc)};
  endfunction

  task automatic model_edge();
    logic st;
    st = m_stall();
    if (flush) begin
      for (int r = 0; r < 8; r++) land[r] = now + 1;
    end else if (issue_valid && !st && issue_we && issue_lat != 2'd0) begin
      land[issue_wsel] = now + 1 + longint'(issue_lat);
    end
    if (st && sc < SC_MAX) sc++;
    now++;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) land[r] = now;
    sc = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] rde, input logic [2:0] rs1,
                      input logic [2:0] rs0, input logic we, input logic [2:0] ws,
                      input logic [1:0] lat, input logic fl,
                      output logic st_o, output logic [7:0] busy_o);
    @(negedge clk);
    issue_valid = v;
    issue_rd_en = rde;
    issue_rs    = {rs1, rs0};
    issue_we    = we;
    issue_wsel  = ws;
    issue_lat   = lat;
    flush       = fl;
    #1;
    check("model", 64'(obs), 64'(m_expect()));
    st_o   = stall;
    busy_o = busy_vec;
    @(posedge clk);
    model_edge();
  endtask

  typedef struct {
    logic       v;
    logic [1:0] rde;
    logic [2:0] rs1;
    logic [2:0] rs0;
    logic       we;
    logic [2:0] ws;
    logic [1:0] lat;
    logic       fl;
    logic       exp_stall;
    logic       exp_stall_f;
    logic [7:0] exp_busy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [1:0] rde, input logic [2:0] rs1,
                              input logic [2:0] rs0, input logic we, input logic [2:0] ws,
                              input logic [1:0] lat, input logic fl, input logic st,
                              input logic stf, input logic [7:0] bv);
    vec_t t;
    t.v = v; t.rde = rde; t.rs1 = rs1; t.rs0 = rs0; t.we = we; t.ws = ws;
    t.lat = lat; t.fl = fl; t.exp_stall = st; t.exp_stall_f = stf; t.exp_busy = bv;
    return t;
  endfunction

  vec_t tbl [20];

  initial begin
    logic       st;
    logic [7:0] bv;
    logic       exp_st;

    // Read-after-write on r3 with latency 3
    tbl[0]  = mk(1, 2'b00, 0, 0, 1, 3, 3, 0, 0, 0, 8'h00);
    tbl[1]  = mk(1, 2'b01, 0, 3, 0, 0, 1, 0, 1, 1, 8'h08);
    tbl[2]  = mk(1, 2'b01, 0, 3, 0, 0, 1, 0, 1, 1, 8'h08);
    tbl[3]  = mk(1, 2'b01, 0, 3, 0, 0, 1, 0, 1, 0, 8'h08);
    tbl[4]  = mk(1, 2'b01, 0, 3, 0, 0, 1, 0, 0, 0, 8'h00);
    // Write-after-write on r5: lat 3 then lat 1
    tbl[5]  = mk(1, 2'b00, 0, 0, 1, 5, 3, 0, 0, 0, 8'h00);
    tbl[6]  = mk(1, 2'b00, 0, 0, 1, 5, 1, 0, 1, 1, 8'h20);
    tbl[7]  = mk(1, 2'b00, 0, 0, 1, 5, 1, 0, 1, 1, 8'h20);
    tbl[8]  = mk(1, 2'b00, 0, 0, 1, 5, 1, 0, 0, 0, 8'h20);
    tbl[9]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h20);
    tbl[10] = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    // Flush while a read of r2 would stall
    tbl[11] = mk(1, 2'b00, 0, 0, 1, 2, 2, 0, 0, 0, 8'h00);
    tbl[12] = mk(1, 2'b10, 2, 0, 0, 0, 1, 1, 0, 0, 8'h04);
    tbl[13] = mk(1, 2'b10, 2, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    // Unused sources never stall; same-register read/write sees the old count
    tbl[14] = mk(1, 2'b00, 0, 0, 1, 6, 3, 0, 0, 0, 8'h00);
    tbl[15] = mk(1, 2'b00, 6, 6, 0, 0, 1, 0, 0, 0, 8'h40);
    tbl[16] = mk(1, 2'b10, 6, 6, 0, 0, 1, 0, 1, 1, 8'h40);
    tbl[17] = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h40);
    tbl[18] = mk(1, 2'b01, 0, 6, 1, 6, 3, 0, 0, 0, 8'h00);
    tbl[19] = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h40);

    for (int r = 0; r < 8; r++) land[r] = 0;
    now = 0;
    sc  = 0;
    rst = 1'b0;
    issue_valid = 1'b0; issue_rd_en = '0; issue_rs = '0; issue_we = 1'b0;
    issue_wsel = '0; issue_lat = 2'd1; flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_state", 64'(obs), 64'({1'b0, 1'b1, 1'b1, 8'h00, 2'b00, 8'h00}));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].v, tbl[i].rde, tbl[i].rs1, tbl[i].rs0, tbl[i].we, tbl[i].ws,
           tbl[i].lat, tbl[i].fl, st, bv);
`ifdef HAZARD_FWD_EN
      exp_st = tbl[i].exp_stall_f;
`else
      exp_st = tbl[i].exp_stall;
`endif
      check($sformatf("tbl_stall[%0d]", i), 64'(st), 64'(exp_st));
      check($sformatf("tbl_busy[%0d]", i), 64'(bv), 64'(tbl[i].exp_busy));
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           2'($urandom_range(1, 3)), ($urandom_range(0, 15) == 0), st, bv);
    end

    // Reset in the middle of a RAW stall on r7
    step(0, 2'b00, 0, 0, 0, 0, 1, 1, st, bv);
    step(1, 2'b00, 0, 0, 1, 7, 3, 0, st, bv);
    @(negedge clk);
    issue_valid = 1'b1; issue_rd_en = 2'b01; issue_rs = {3'd0, 3'd7};
    issue_we = 1'b0; issue_wsel = 3'd0; issue_lat = 2'd1; flush = 1'b0;
    #1;
    check("pre_rst_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_stall", 64'(obs), 64'({1'b0, 1'b1, 1'b1, 8'h00, 2'b00, 8'h00}));
    model_reset();
    rst = 1'b0;
    #1;
    check("first_issue_after_rst", 64'(stall), 64'd0);
    @(posedge clk);
    model_edge();

    // Repeated RAW stalls on r1 until the perf counter saturates
    for (int i = 0; i < 140; i++) begin
      step(1, 2'b00, 0, 0, 1, 1, 3, 0, st, bv);
      for (int j = 0; j < 4; j++) step(1, 2'b01, 0, 1, 0, 0, 1, 0, st, bv);
    end
    #1;
    check("stall_cnt_sat", 64'(stall_cnt), 64'(SC_MAX));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
